// File: rtl/vector_lane_sequencer.sv
// rtl/vector_lane_sequencer.sv - serializes a vector instruction over the scalar ALU one lane per cycle
module vector_lane_sequencer #(
    parameter int N       = 24,
    parameter int LANES   = 4,
    parameter int ALU_LAT = 1,
    parameter int LW      = $clog2(LANES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          StartE,
    input  logic [LW:0]   VLenE,
    input  logic          FlushE,
    output logic          LaneIssue,
    output logic [LW-1:0] LaneIdx,
    output logic          LaneWB,
    output logic [LW-1:0] LaneWBIdx,
    output logic          Stuck,
    output logic          Busy,
    output logic          Done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam int DCW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(ALU_LAT - 1);
    localparam logic [LW:0]    LANES_L    = LANES[LW:0];

    // Word width is carried for interface uniformity only; no data passes here.
    if (N < 1) begin : g_bad_n
    end

    logic [1:0]                     state_q, state_d;
    logic [LW-1:0]                  cnt_q, cnt_d;
    logic [LW:0]                    len_q, len_d;
    logic [DCW-1:0]                 dcnt_q, dcnt_d;
    logic [ALU_LAT-1:0]             pipe_v_q, pipe_v_d;
    logic [ALU_LAT-1:0][LW-1:0]     pipe_idx_q, pipe_idx_d;
    logic [ALU_LAT-1:0]             shift_v;
    logic [ALU_LAT-1:0][LW-1:0]     shift_idx;

    logic          start_ok;
    logic [LW:0]   len_in;
    logic          last_issue;
    logic          drain_last;
    logic          push;

    assign start_ok   = StartE & (VLenE != '0) & ~FlushE;
    assign len_in     = (VLenE > LANES_L) ? LANES_L : VLenE;
    assign last_issue = ({1'b0, cnt_q} == (len_q - 1'b1));
    assign drain_last = (dcnt_q == DRAIN_LAST);
    assign push       = (state_q == S_ISSUE);

    // In-flight pipe: entry 0 takes the lane issued this cycle, the top entry is the writeback.
    if (ALU_LAT > 1) begin : g_shift
        assign shift_v   = {pipe_v_q[ALU_LAT-2:0], push};
        assign shift_idx = {pipe_idx_q[ALU_LAT-2:0], (push ? cnt_q : {LW{1'b0}})};
    end else begin : g_noshift
        assign shift_v   = push;
        assign shift_idx = push ? cnt_q : {LW{1'b0}};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        dcnt_d     = dcnt_q;
        pipe_v_d   = shift_v;
        pipe_idx_d = shift_idx;
        if (FlushE) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            dcnt_d     = '0;
            pipe_v_d   = '0;
            pipe_idx_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        len_d   = len_in;
                        cnt_d   = '0;
                        dcnt_d  = '0;
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Counter parks on the last lane rather than wrapping.
                    if (last_issue) begin
                        state_d = S_DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_last) begin
                        state_d = S_IDLE;
                        dcnt_d  = '0;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            dcnt_q     <= '0;
            pipe_v_q   <= '0;
            pipe_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            dcnt_q     <= dcnt_d;
            pipe_v_q   <= pipe_v_d;
            pipe_idx_q <= pipe_idx_d;
        end
    end

    assign LaneIssue = (state_q == S_ISSUE) & ~FlushE;
    assign LaneIdx   = LaneIssue ? cnt_q : '0;
    assign LaneWB    = pipe_v_q[ALU_LAT-1] & ~FlushE;
    assign LaneWBIdx = LaneWB ? pipe_idx_q[ALU_LAT-1] : '0;
    assign Done      = (state_q == S_DRAIN) & drain_last & ~FlushE;
    assign Busy      = (state_q != S_IDLE);

    // The IDLE term is combinational on StartE, so reset must gate it explicitly.
    assign Stuck = rst & ~FlushE &
                   (((state_q == S_IDLE) & start_ok) |
                    (state_q == S_ISSUE) |
                    ((state_q == S_DRAIN) & ~drain_last));

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// tb/tb_vector_lane_sequencer.sv - directed bench for vector_lane_sequencer
module tb_vector_lane_sequencer;

    localparam int LW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          StartE;
    logic [LW:0]   VLenE;
    logic          FlushE;

    logic          a_iss, a_wb, a_stuck, a_busy, a_done;
    logic [LW-1:0] a_idx, a_wbidx;
    logic          b_iss, b_wb, b_stuck, b_busy, b_done;
    logic [LW-1:0] b_idx, b_wbidx;

    logic [8:0]    obs_a, obs_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    vector_lane_sequencer #(.N(24), .LANES(4), .ALU_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .StartE(StartE), .VLenE(VLenE), .FlushE(FlushE),
        .LaneIssue(a_iss), .LaneIdx(a_idx), .LaneWB(a_wb), .LaneWBIdx(a_wbidx),
        .Stuck(a_stuck), .Busy(a_busy), .Done(a_done)
    );

    vector_lane_sequencer #(.N(24), .LANES(4), .ALU_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .StartE(StartE), .VLenE(VLenE), .FlushE(FlushE),
        .LaneIssue(b_iss), .LaneIdx(b_idx), .LaneWB(b_wb), .LaneWBIdx(b_wbidx),
        .Stuck(b_stuck), .Busy(b_busy), .Done(b_done)
    );

    assign obs_a = {a_iss, a_idx, a_wb, a_wbidx, a_stuck, a_busy, a_done};
    assign obs_b = {b_iss, b_idx, b_wb, b_wbidx, b_stuck, b_busy, b_done};

    function automatic logic [8:0] ev(input bit iss, input int idx, input bit wb, input int wbidx,
                                      input bit stuck, input bit busy, input bit done);
        return {iss, 2'(idx), wb, 2'(wbidx), stuck, busy, done};
    endfunction

    // Expected outputs in cycle c of a sequence (cycle 0 = StartE seen in IDLE).
    function automatic logic [8:0] exp_at(input int len, input int lat, input int c);
        bit iss;
        bit wb;
        iss = (c >= 1) && (c <= len);
        wb  = (c >= 1 + lat) && (c <= len + lat);
        return ev(iss, iss ? c - 1 : 0, wb, wb ? c - 1 - lat : 0,
                  c <= len + lat - 1, (c >= 1) && (c <= len + lat), c == len + lat);
    endfunction

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b (iss,idx,wb,wbidx,stuck,busy,done)", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one full sequence; StartE/VLenE are wiggled while busy and must be ignored.
    task automatic run_seq(input string tag, input int vlen, input int len, input bit use_b);
        int lat;
        lat = use_b ? 3 : 1;
        for (int c = 0; c <= len + lat; c++) begin
            if (c == 0) begin
                StartE = 1'b1;
                VLenE  = 3'(vlen);
            end else begin
                StartE = c[0];
                VLenE  = 3'(c);
            end
            #2;
            chk($sformatf("%s c%0d", tag, c), use_b ? obs_b : obs_a, exp_at(len, lat, c));
            tick();
        end
    endtask

    task automatic idle(input string tag, input int n, input bit check);
        StartE = 1'b0;
        FlushE = 1'b0;
        for (int i = 0; i < n; i++) begin
            #2;
            if (check) chk($sformatf("%s %0d", tag, i), obs_a, 9'd0);
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b0;
        StartE = 1'b1;
        VLenE  = 3'd4;
        FlushE = 1'b0;
        #2;
        chk("reset_a", obs_a, 9'd0);
        chk("reset_b", obs_b, 9'd0);
        tick();
        tick();
        #2;
        chk("reset_hold_a", obs_a, 9'd0);
        tick();
        rst = 1'b1;

        run_seq("main", 4, 4, 1'b0);
        run_seq("b2b", 4, 4, 1'b0);
        run_seq("len1", 1, 1, 1'b0);
        idle("gap1", 3, 1'b1);
        run_seq("len7", 7, 4, 1'b0);
        idle("gap2", 2, 1'b1);

        StartE = 1'b1;
        VLenE  = 3'd0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk($sformatf("len0 %0d", i), obs_a, 9'd0);
            tick();
        end
        idle("gap3", 2, 1'b1);

        StartE = 1'b1;
        VLenE  = 3'd4;
        #2;
        chk("flush c0", obs_a, exp_at(4, 1, 0));
        tick();
        StartE = 1'b0;
        #2;
        chk("flush c1", obs_a, exp_at(4, 1, 1));
        tick();
        FlushE = 1'b1;
        #2;
        chk("flush c2", obs_a, ev(0, 0, 0, 0, 0, 1, 0));
        tick();
        FlushE = 1'b0;
        idle("flush_after", 5, 1'b1);

        idle("gap4", 10, 1'b0);
        run_seq("lat3", 2, 2, 1'b1);
        idle("gap5", 8, 1'b0);

        StartE = 1'b1;
        VLenE  = 3'd4;
        #2;
        chk("areset c0", obs_a, exp_at(4, 1, 0));
        tick();
        StartE = 1'b0;
        #2;
        chk("areset c1", obs_a, exp_at(4, 1, 1));
        tick();
        StartE = 1'b1;
        #2;
        chk("areset c2", obs_a, exp_at(4, 1, 2));
        #1;
        rst = 1'b0;
        #1;
        chk("areset now_a", obs_a, 9'd0);
        chk("areset now_b", obs_b, 9'd0);
        tick();
        #2;
        chk("areset held", obs_a, 9'd0);
        StartE = 1'b0;
        rst    = 1'b1;
        tick();
        idle("areset_after", 5, 1'b1);
        run_seq("post_rst", 4, 4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
